// File: rtl/gest_interrup_vec_pkg.sv
// Purpose : shared types and helpers for the vectored interrupt controller.
// Latency : n/a (types, constants and a pure function only).
// Backpressure : n/a.
// Contents: FSM state type, default vector geometry, and the vector address
// function, which the control-unit bench reuses to predict PC targets.
package gest_interrup_vec_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   localparam int         DEF_ADDR_W     = 10;
   localparam logic [9:0] DEF_VEC_BASE   = 10'd984;
   localparam logic [9:0] DEF_VEC_STRIDE = 10'd10;

   // Untruncated vector address. The caller truncates to its own PC width.
   function automatic int unsigned vec_addr(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned id);
      return base + id * stride;
   endfunction

endpackage

// File: rtl/gest_interrup_vec_sync_edge.sv
// Purpose : two-flop synchroniser for one raw interrupt line, plus rise detect.
// Latency : s_o follows irq_i after 2 edges; rise_o is high for 1 cycle after s_o rises.
// Backpressure : none; free-running sampler.
// Ports: clk_i/rst_ni clock and async active-low reset; irq_i raw async line;
//        s_o synchronised level; rise_o = s_o & ~(s_o delayed one cycle).
module irq_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_i,
   output logic s_o,
   output logic rise_o
);

   logic meta_q;
   logic s_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         s_q    <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= irq_i;
         s_q    <= meta_q;
         prev_q <= s_q;
      end
   end

   assign s_o    = s_q;
   assign rise_o = s_q & ~prev_q;

endmodule

// File: rtl/gest_interrup_vec.sv
// Purpose : vectored fixed-priority interrupt controller feeding the CPU PC mux.
// Latency : irq_in rise -> s_interrup after 4 edges; next request >= 1 cycle after ack.
// Backpressure : request held frozen (no re-arbitration) until the CPU acks.
// Ports: clk, reset (async active-low); irq_in raw lines; irq_mask enables;
//        ack CPU loaded PC from dir; fin return-from-interrupt;
//        s_interrup/dir/irq_id request + vector; pending/in_service status.
module gest_interrup_vec
   import gest_interrup_vec_pkg::*;
#(
   parameter int                  NUM_SRC    = 4,
   parameter int                  ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0]   VEC_BASE   = DEF_VEC_BASE,
   parameter logic [ADDR_W-1:0]   VEC_STRIDE = DEF_VEC_STRIDE,
   parameter logic [NUM_SRC-1:0]  EDGE_MODE  = {NUM_SRC{1'b1}},
   parameter bit                  NESTING    = 1'b1,
   localparam int                 ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               ack,
   input  logic               fin,
   output logic               s_interrup,
   output logic [ADDR_W-1:0]  dir,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] in_service
);

   // Elaboration-time guards on the parameter set.
   if (NUM_SRC < 1 || NUM_SRC > 16) begin : g_num_src_err
      $error("gest_interrup_vec: NUM_SRC must be within 1..16");
   end
   if (64'(VEC_BASE) + 64'(NUM_SRC - 1) * 64'(VEC_STRIDE) >= (64'd1 << ADDR_W)) begin : g_vec_range_err
      $error("gest_interrup_vec: highest vector does not fit in ADDR_W bits");
   end

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [NUM_SRC-1:0] s;
   logic [NUM_SRC-1:0] rise;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk_i  (clk),
         .rst_ni (reset),
         .irq_i  (irq_in[g]),
         .s_o    (s[g]),
         .rise_o (rise[g])
      );
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] in_service_q, in_service_d;
   logic [ADDR_W-1:0]  dir_q;
   logic [ID_W-1:0]    irq_id_q;

   logic [NUM_SRC-1:0] prio_ok;
   logic [NUM_SRC-1:0] eligible;
   logic               any_elig;
   logic [ID_W-1:0]    winner;
   logic [ADDR_W-1:0]  vec_dir;
   logic               load_vec;
   logic               take;
   logic [NUM_SRC-1:0] ack_set;
   logic [NUM_SRC-1:0] fin_clr;

   // prio_ok[i]: nothing in service, or (nesting) no in-service bit at index <= i,
   // i.e. i is strictly above the lowest active ISR in priority.
   always_comb begin : p_prio
      logic seen;
      seen    = 1'b0;
      prio_ok = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         seen       = seen | in_service_q[i];
         prio_ok[i] = (in_service_q == '0) || (NESTING && !seen);
      end
   end

   assign eligible = pending_q & irq_mask & ~in_service_q & prio_ok;

   // Fixed priority: scanning downwards leaves the lowest eligible index.
   always_comb begin : p_arb
      winner   = '0;
      any_elig = |eligible;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   assign vec_dir = ADDR_W'(vec_addr(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(winner)));

   // ------------------------------------------------------------------
   // Pending / in-service next state
   // ------------------------------------------------------------------
   always_comb begin : p_status
      ack_set = take ? (NUM_SRC'(1) << irq_id_q) : '0;
      // fin retires the lowest set bit (the most recently nested ISR); it
      // works on the old value, so a same-cycle ack bit is kept.
      fin_clr      = fin ? (in_service_q & (~in_service_q + NUM_SRC'(1))) : '0;
      in_service_d = (in_service_q & ~fin_clr) | ack_set;
      for (int i = 0; i < NUM_SRC; i++) begin
         // Edge channel: a new rise wins over the ack clear in the same cycle.
         pending_d[i] = EDGE_MODE[i] ? (rise[i] | (pending_q[i] & ~ack_set[i]))
                                     : s[i];
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : p_next
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_elig) state_d = REQ;
         REQ:     if (ack)      state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_comb begin : p_out
      s_interrup = (state_q == REQ);
      load_vec   = (state_q == IDLE) && any_elig;
      take       = (state_q == REQ) && ack;
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q    <= '0;
         in_service_q <= '0;
         dir_q        <= '0;
         irq_id_q     <= '0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         // Vector is captured only when a request is launched; it stays
         // frozen during REQ and is held after the ack.
         if (load_vec) begin
            dir_q    <= vec_dir;
            irq_id_q <= winner;
         end
      end
   end

   assign dir        = dir_q;
   assign irq_id     = irq_id_q;
   assign pending    = pending_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_gest_interrup_vec.sv
// Purpose : directed self-checking bench for gest_interrup_vec.
// Latency : n/a.
// Backpressure : n/a.
module tb_gest_interrup_vec;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   // Nesting, all-edge instance
   logic [3:0] irq_in, irq_mask;
   logic       ack, fin;
   logic       s_int;
   logic [9:0] dir;
   logic [1:0] id;
   logic [3:0] pend, isr;
   // Non-nesting instance, channel 3 level-sensitive
   logic [3:0] irq_in_n, mask_n;
   logic       ack_n, fin_n;
   logic       s_int_n;
   logic [9:0] dir_n;
   logic [1:0] id_n;
   logic [3:0] pend_n, isr_n;

   int checks = 0;
   int errors = 0;

   gest_interrup_vec #(.NUM_SRC(4), .ADDR_W(10), .VEC_BASE(10'd984), .VEC_STRIDE(10'd10),
                       .EDGE_MODE(4'b1111), .NESTING(1'b1)) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask), .ack(ack), .fin(fin),
      .s_interrup(s_int), .dir(dir), .irq_id(id), .pending(pend), .in_service(isr));

   gest_interrup_vec #(.NUM_SRC(4), .ADDR_W(10), .VEC_BASE(10'd984), .VEC_STRIDE(10'd10),
                       .EDGE_MODE(4'b0111), .NESTING(1'b0)) dut_nn (
      .clk(clk), .reset(reset), .irq_in(irq_in_n), .irq_mask(mask_n), .ack(ack_n), .fin(fin_n),
      .s_interrup(s_int_n), .dir(dir_n), .irq_id(id_n), .pending(pend_n), .in_service(isr_n));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      irq_in = 4'h0; irq_mask = 4'hF; ack = 1'b0; fin = 1'b0;
      irq_in_n = 4'h0; mask_n = 4'hF; ack_n = 1'b0; fin_n = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   // Drive a one-cycle pulse then wait until the 4th edge after it was raised.
   task automatic pulse_and_wait(input logic [3:0] v);
      irq_in = v;
      tick(1);
      irq_in = 4'h0;
      tick(3);
   endtask

   task automatic pulse_and_wait_n(input logic [3:0] v);
      irq_in_n = v;
      tick(1);
      irq_in_n = 4'h0;
      tick(3);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      irq_in = 4'hF; irq_mask = 4'hF; ack = 1'b0; fin = 1'b0;
      irq_in_n = 4'h0; mask_n = 4'hF; ack_n = 1'b0; fin_n = 1'b0;
      tick(3);
      checks++; if ({s_int, dir, id, pend, isr} !== 24'h0) begin errors++;
         $display("FAIL reset_outputs: got %h expected %h", {s_int, dir, id, pend, isr}, 24'h0); end
      checks++; if ({s_int_n, dir_n, id_n, pend_n, isr_n} !== 24'h0) begin errors++;
         $display("FAIL reset_outputs_nn: got %h expected %h", {s_int_n, dir_n, id_n, pend_n, isr_n}, 24'h0); end
      reset = 1'b1;
      tick(3);
      checks++; if ({s_int, pend} !== {1'b0, 4'hF}) begin errors++;
         $display("FAIL reset_edge3: got %h expected %h", {s_int, pend}, {1'b0, 4'hF}); end
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd984, 2'd0}) begin errors++;
         $display("FAIL reset_edge4_req: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd984, 2'd0}); end
      ack = 1'b1; tick(1); ack = 1'b0;
      checks++; if ({s_int, pend, isr} !== {1'b0, 4'b1110, 4'b0001}) begin errors++;
         $display("FAIL reset_ack: got %h expected %h", {s_int, pend, isr}, {1'b0, 4'b1110, 4'b0001}); end
      tick(1);
      checks++; if (s_int !== 1'b0) begin errors++;
         $display("FAIL reset_blocked_by_isr0: got %b expected %b", s_int, 1'b0); end
      irq_in = 4'h0;
   endtask

   task automatic test_single_edge();
      do_reset();
      irq_in = 4'b0100; tick(1); irq_in = 4'h0; tick(2);
      checks++; if (s_int !== 1'b0) begin errors++;
         $display("FAIL single_early: got %b expected %b", s_int, 1'b0); end
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd1004, 2'd2}) begin errors++;
         $display("FAIL single_req: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd1004, 2'd2}); end
      ack = 1'b1; tick(1); ack = 1'b0;
      checks++; if ({s_int, dir, pend, isr} !== {1'b0, 10'd1004, 4'b0000, 4'b0100}) begin errors++;
         $display("FAIL single_ack: got %h expected %h", {s_int, dir, pend, isr}, {1'b0, 10'd1004, 4'b0000, 4'b0100}); end
      fin = 1'b1; tick(1); fin = 1'b0;
      checks++; if (isr !== 4'b0000) begin errors++;
         $display("FAIL single_fin: got %b expected %b", isr, 4'b0000); end
   endtask

   task automatic test_priority();
      do_reset();
      pulse_and_wait(4'b1010);
      checks++; if ({s_int, dir, id, pend} !== {1'b1, 10'd994, 2'd1, 4'b1010}) begin errors++;
         $display("FAIL prio_first: got %h expected %h", {s_int, dir, id, pend}, {1'b1, 10'd994, 2'd1, 4'b1010}); end
      ack = 1'b1; tick(1); ack = 1'b0;
      checks++; if ({pend, isr} !== {4'b1000, 4'b0010}) begin errors++;
         $display("FAIL prio_ack: got %h expected %h", {pend, isr}, {4'b1000, 4'b0010}); end
      tick(1);
      checks++; if (s_int !== 1'b0) begin errors++;
         $display("FAIL prio_lower_blocked: got %b expected %b", s_int, 1'b0); end
      fin = 1'b1; tick(1); fin = 1'b0;
      checks++; if ({s_int, isr} !== {1'b0, 4'b0000}) begin errors++;
         $display("FAIL prio_fin: got %h expected %h", {s_int, isr}, {1'b0, 4'b0000}); end
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd1014, 2'd3}) begin errors++;
         $display("FAIL prio_second: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd1014, 2'd3}); end
   endtask

   task automatic test_freeze();
      do_reset();
      pulse_and_wait(4'b0100);
      pulse_and_wait(4'b0001);
      checks++; if ({s_int, dir, id, pend} !== {1'b1, 10'd1004, 2'd2, 4'b0101}) begin errors++;
         $display("FAIL freeze_req: got %h expected %h", {s_int, dir, id, pend}, {1'b1, 10'd1004, 2'd2, 4'b0101}); end
      ack = 1'b1; tick(1); ack = 1'b0;
      checks++; if ({s_int, pend, isr} !== {1'b0, 4'b0001, 4'b0100}) begin errors++;
         $display("FAIL freeze_ack: got %h expected %h", {s_int, pend, isr}, {1'b0, 4'b0001, 4'b0100}); end
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd984, 2'd0}) begin errors++;
         $display("FAIL freeze_next: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd984, 2'd0}); end
   endtask

   task automatic test_nesting();
      do_reset();
      pulse_and_wait(4'b1000);
      ack = 1'b1; tick(1); ack = 1'b0;
      pulse_and_wait(4'b0001);
      checks++; if ({s_int, dir, id, isr} !== {1'b1, 10'd984, 2'd0, 4'b1000}) begin errors++;
         $display("FAIL nest_preempt: got %h expected %h", {s_int, dir, id, isr}, {1'b1, 10'd984, 2'd0, 4'b1000}); end
      ack = 1'b1; tick(1); ack = 1'b0;
      checks++; if (isr !== 4'b1001) begin errors++;
         $display("FAIL nest_isr: got %b expected %b", isr, 4'b1001); end
      fin = 1'b1; tick(1); fin = 1'b0;
      checks++; if (isr !== 4'b1000) begin errors++;
         $display("FAIL nest_fin_lowest: got %b expected %b", isr, 4'b1000); end
      // Same sequence with nesting disabled.
      do_reset();
      pulse_and_wait_n(4'b0100);
      checks++; if ({s_int_n, id_n} !== {1'b1, 2'd2}) begin errors++;
         $display("FAIL nonest_first: got %h expected %h", {s_int_n, id_n}, {1'b1, 2'd2}); end
      ack_n = 1'b1; tick(1); ack_n = 1'b0;
      pulse_and_wait_n(4'b0001);
      tick(3);
      checks++; if ({s_int_n, pend_n, isr_n} !== {1'b0, 4'b0001, 4'b0100}) begin errors++;
         $display("FAIL nonest_no_preempt: got %h expected %h", {s_int_n, pend_n, isr_n}, {1'b0, 4'b0001, 4'b0100}); end
      fin_n = 1'b1; tick(1); fin_n = 1'b0;
      tick(1);
      checks++; if ({s_int_n, dir_n, id_n, isr_n} !== {1'b1, 10'd984, 2'd0, 4'b0000}) begin errors++;
         $display("FAIL nonest_after_fin: got %h expected %h", {s_int_n, dir_n, id_n, isr_n}, {1'b1, 10'd984, 2'd0, 4'b0000}); end
   endtask

   task automatic test_level();
      do_reset();
      irq_in_n = 4'b1000;
      tick(2);
      checks++; if (pend_n !== 4'b0000) begin errors++;
         $display("FAIL level_early: got %b expected %b", pend_n, 4'b0000); end
      tick(1);
      checks++; if (pend_n !== 4'b1000) begin errors++;
         $display("FAIL level_pending: got %b expected %b", pend_n, 4'b1000); end
      tick(1);
      checks++; if ({s_int_n, dir_n, id_n} !== {1'b1, 10'd1014, 2'd3}) begin errors++;
         $display("FAIL level_req: got %h expected %h", {s_int_n, dir_n, id_n}, {1'b1, 10'd1014, 2'd3}); end
      ack_n = 1'b1; tick(1); ack_n = 1'b0;
      checks++; if ({pend_n, isr_n} !== {4'b1000, 4'b1000}) begin errors++;
         $display("FAIL level_ack_no_clear: got %h expected %h", {pend_n, isr_n}, {4'b1000, 4'b1000}); end
      irq_in_n = 4'h0;
      tick(2);
      checks++; if (pend_n !== 4'b1000) begin errors++;
         $display("FAIL level_drop_lag: got %b expected %b", pend_n, 4'b1000); end
      tick(1);
      checks++; if (pend_n !== 4'b0000) begin errors++;
         $display("FAIL level_drop: got %b expected %b", pend_n, 4'b0000); end
   endtask

   task automatic test_mask();
      do_reset();
      irq_mask = 4'b1101;
      pulse_and_wait(4'b0010);
      tick(2);
      checks++; if ({s_int, pend} !== {1'b0, 4'b0010}) begin errors++;
         $display("FAIL mask_held: got %h expected %h", {s_int, pend}, {1'b0, 4'b0010}); end
      irq_mask = 4'hF;
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd994, 2'd1}) begin errors++;
         $display("FAIL mask_unmask_req: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd994, 2'd1}); end
   endtask

   task automatic test_corners();
      // fin and ack in the same cycle
      do_reset();
      pulse_and_wait(4'b0010);
      ack = 1'b1; tick(1); ack = 1'b0;
      pulse_and_wait(4'b0001);
      checks++; if ({s_int, id, isr} !== {1'b1, 2'd0, 4'b0010}) begin errors++;
         $display("FAIL corner_pre_finack: got %h expected %h", {s_int, id, isr}, {1'b1, 2'd0, 4'b0010}); end
      ack = 1'b1; fin = 1'b1; tick(1); ack = 1'b0; fin = 1'b0;
      checks++; if ({s_int, isr} !== {1'b0, 4'b0001}) begin errors++;
         $display("FAIL corner_finack: got %h expected %h", {s_int, isr}, {1'b0, 4'b0001}); end
      // new rising edge on the ack cycle keeps pending set
      do_reset();
      pulse_and_wait(4'b0100);
      irq_in = 4'b0100;
      tick(2);
      ack = 1'b1; tick(1); ack = 1'b0; irq_in = 4'h0;
      checks++; if ({s_int, pend, isr} !== {1'b0, 4'b0100, 4'b0100}) begin errors++;
         $display("FAIL corner_edge_on_ack: got %h expected %h", {s_int, pend, isr}, {1'b0, 4'b0100, 4'b0100}); end
      fin = 1'b1; tick(1); fin = 1'b0;
      tick(1);
      checks++; if ({s_int, dir, id} !== {1'b1, 10'd1004, 2'd2}) begin errors++;
         $display("FAIL corner_rerequest: got %h expected %h", {s_int, dir, id}, {1'b1, 10'd1004, 2'd2}); end
      // asynchronous reset while a request is outstanding
      do_reset();
      pulse_and_wait(4'b0010);
      checks++; if (s_int !== 1'b1) begin errors++;
         $display("FAIL corner_pre_areset: got %b expected %b", s_int, 1'b1); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({s_int, dir, id, pend, isr} !== 24'h0) begin errors++;
         $display("FAIL corner_async_reset: got %h expected %h", {s_int, dir, id, pend, isr}, 24'h0); end
      tick(1);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_priority();
      test_freeze();
      test_nesting();
      test_level();
      test_mask();
      test_corners();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
